imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits between a byte-stream source (UART receiver or test harness) and the instruction memory's load port. It takes a length header and little-endian instruction bytes, assembles 32-bit words, and drives one-cycle write strobes into the memory. It pads the unused tail with NOPs so the memory's internal write counter reaches its last entry. Once the memory reports load completion, it releases the core.

## Interface
- DEPTH, 256, instruction memory entries; the memory raises load_done only after exactly DEPTH writes.
- NOP_WORD, 32'h0000_0013, fill word for entries past the program (addi x0,x0,0).
- DONE_TIMEOUT, 16, cycles to wait for mem_load_done after the final write.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready.
- mem_load_en  out  1  write strobe to instruction memory.
- mem_load_inst  out  32  word written when mem_load_en=1.
- mem_load_done  in  1  memory full indication.
- busy  out  1  high in HDR0, HDR1, DATA, WR, PAD and WAIT_DONE.
- cpu_run  out  1  core release; sticky high in RUN.
- err  out  1  sticky error flag.
- words_written  out  9  count of mem_load_en pulses issued, range 0..DEPTH.

## Operation
- States: IDLE, HDR0, HDR1, DATA, WR, PAD, WAIT_DONE, RUN, ERR.
- IDLE:
  - If start=1 and mem_load_done=1, go to ERR. The memory is already full and only a reset clears it.
  - If start=1 otherwise, go to HDR0.
- HDR0 and HDR1 (rx_ready=1):
  - Accept the low byte, then the high byte, of the 16-bit word count N.
  - On accepting the high byte: if N==0 or N>DEPTH, go to ERR; otherwise go to DATA.
- DATA (rx_ready=1):
  - Accept bytes little-endian into a 32-bit shift register: byte k of the word lands in bits [8k+7:8k].
  - On accepting the 4th byte, go to WR.
- WR (rx_ready=0):
  - mem_load_en=1, mem_load_inst=assembled word, words_written increments.
  - Next state: DATA if words_written+1 < N. Otherwise PAD if N < DEPTH. Otherwise WAIT_DONE.
- PAD (rx_ready=0):
  - mem_load_en=1 with NOP_WORD every cycle, words_written increments each cycle.
  - Leave for WAIT_DONE on the cycle that issues write number DEPTH.
- WAIT_DONE:
  - If mem_load_done=1, go to RUN.
  - If DONE_TIMEOUT cycles elapse without it, go to ERR.
- RUN: cpu_run=1; terminal until rst; start ignored.
- ERR: err=1; terminal until rst; start and rx ignored.
- If mem_load_done rises before write number DEPTH has been issued, go to ERR immediately from any busy state.
- mem_load_en is never asserted outside WR and PAD. words_written never exceeds DEPTH.
- The top level drives the memory's active-low reset from the same source as rst. A reset mid-load therefore restarts both blocks coherently.

## Timing
- Reset values:
  - state=IDLE.
  - rx_ready=0, mem_load_en=0, mem_load_inst=0.
  - busy=0, cpu_run=0, err=0, words_written=0.
  - Timeout counter=0, byte index=0.
- All outputs are registered or decoded from state; there is no combinational path from rx_valid to rx_ready.
- Write timing: mem_load_en is asserted the cycle after the 4th byte is accepted.
- Best-case throughput: 5 cycles per word (4 accept cycles + 1 WR cycle).
- Padding: DEPTH−N consecutive cycles.
- The memory registers load_done one cycle after its final write. The loader therefore sees mem_load_done=1 in its first or second WAIT_DONE cycle; RUN follows on the next cycle.
- rx_valid gaps stall DATA indefinitely; there is no timeout in DATA or HDR.
- Simultaneous start and rst: rst wins.
- Timeout counter: resets on entry to WAIT_DONE; ERR when the count reaches DONE_TIMEOUT.

## Test plan
- N=2, bytes 02 00 | 93 00 10 00 | 13 01 20 00, memory model attached:
  - Writes 0x00100093, then 0x00200113, then 254 NOP_WORD writes.
  - words_written=256, mem_load_done rises, then cpu_run=1 with err=0.
- N=256, rx_valid deasserted 3 cycles between every byte:
  - Exactly 256 strobes, no PAD cycles.
  - rx_ready=0 during every WR cycle.
  - Final state RUN.
- Header 00 00, then separately 01 01 (N=257):
  - Each case: err=1 after the second header byte, no mem_load_en pulse, rx_ready=0 afterwards.
- mem_load_done tied 0:
  - After write 256, err=1 exactly DONE_TIMEOUT cycles after entering WAIT_DONE; cpu_run stays 0.
- rst asserted mid-DATA after 10 words:
  - Next cycle: all outputs at reset values, words_written=0.
  - A fresh N=1 load completes with 0x00000013 padding and cpu_run=1.
- start with mem_load_done already 1: err=1 the next cycle, no writes issued.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot loader turning a length-prefixed byte stream into
// instruction-memory write strobes, NOP-padded, then releasing the core.
module imem_loader #(
  parameter int          DEPTH        = 256,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013,
  parameter int          DONE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_load_en,
  output logic [31:0] mem_load_inst,
  input  logic        mem_load_done,
  output logic        busy,
  output logic        cpu_run,
  output logic        err,
  output logic [8:0]  words_written
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [8:0]    W_DEPTH   = 9'(DEPTH);
  localparam logic [15:0]   N_DEPTH   = 16'(DEPTH);
  localparam logic [TW-1:0] W_TO_LAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WR,
    S_PAD,
    S_WAIT,
    S_RUN,
    S_ERR
  } state_t;

  state_t        r_state;
  logic [15:0]   r_n;
  logic [23:0]   r_sh;
  logic [1:0]    r_idx;
  logic [31:0]   r_inst;
  logic [8:0]    r_cnt;
  logic [TW-1:0] r_to;

  logic [15:0] w_n;
  logic [8:0]  w_cnt_inc;
  logic        w_more;
  logic        w_busy;
  logic        w_wr;

  assign w_n       = {rx_data, r_n[7:0]};
  assign w_cnt_inc = r_cnt + 9'd1;
  assign w_more    = {7'd0, w_cnt_inc} < r_n;
  assign w_wr      = (r_state == S_WR) || (r_state == S_PAD);
  assign w_busy    = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                     (r_state == S_DATA) || w_wr ||
                     (r_state == S_WAIT);

  assign rx_ready      = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                         (r_state == S_DATA);
  assign mem_load_en   = w_wr;
  assign mem_load_inst = r_inst;
  assign busy          = w_busy;
  assign cpu_run       = (r_state == S_RUN);
  assign err           = (r_state == S_ERR);
  assign words_written = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_sh    <= '0;
      r_idx   <= '0;
      r_inst  <= '0;
      r_cnt   <= '0;
      r_to    <= '0;
    end else begin
      if (w_wr) begin
        r_cnt <= w_cnt_inc;
      end
      // A full memory before our last write means it was not reset with us
      if (w_busy && mem_load_done && r_cnt != W_DEPTH) begin
        r_state <= S_ERR;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= mem_load_done ? S_ERR : S_HDR0;
            end
          end
          S_HDR0: begin
            if (rx_valid) begin
              r_n[7:0] <= rx_data;
              r_state  <= S_HDR1;
            end
          end
          S_HDR1: begin
            if (rx_valid) begin
              r_n <= w_n;
              if (w_n == 16'd0 || w_n > N_DEPTH) begin
                r_state <= S_ERR;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              r_sh  <= {rx_data, r_sh[23:8]};
              r_idx <= r_idx + 2'd1;
              if (r_idx == 2'd3) begin
                r_inst  <= {rx_data, r_sh};
                r_state <= S_WR;
              end
            end
          end
          S_WR: begin
            if (w_more) begin
              r_state <= S_DATA;
            end else if (r_n < N_DEPTH) begin
              r_inst  <= NOP_WORD;
              r_state <= S_PAD;
            end else begin
              r_to    <= '0;
              r_state <= S_WAIT;
            end
          end
          S_PAD: begin
            if (w_cnt_inc == W_DEPTH) begin
              r_to    <= '0;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_load_done) begin
              r_state <= S_RUN;
            end else if (r_to == W_TO_LAST) begin
              r_state <= S_ERR;
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader with an attached
// instruction-memory model that raises load_done after DEPTH writes.
module tb_imem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          TO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_load_en;
  logic [31:0] mem_load_inst;
  logic        mem_load_done;
  logic        busy;
  logic        cpu_run;
  logic        err;
  logic [8:0]  words_written;

  imem_loader #(
    .DEPTH(DEPTH),
    .NOP_WORD(NOP),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_load_en(mem_load_en),
    .mem_load_inst(mem_load_inst),
    .mem_load_done(mem_load_done),
    .busy(busy),
    .cpu_run(cpu_run),
    .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_en = 0;
  int cyc = 0;
  int last_en = 0;
  logic [31:0] q[$];

  logic       tie0 = 1'b0;
  logic       force1 = 1'b0;
  logic [8:0] mcnt;
  logic       mdone;

  // memory model: done registered with the final write
  always @(posedge clk) begin
    if (rst) begin
      mcnt  <= '0;
      mdone <= 1'b0;
    end else if (mem_load_en) begin
      mcnt <= mcnt + 9'd1;
      if (mcnt == 9'(DEPTH - 1)) mdone <= 1'b1;
    end
  end

  assign mem_load_done = force1 | (mdone & ~tie0);

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && mem_load_en) begin
      n_en++;
      last_en = cyc;
      e = (q.size() != 0) ? q.pop_front() : ~mem_load_inst;
      chk("wr_word", mem_load_inst, e);
      chk("rdy_in_wr", {31'd0, rx_ready}, 32'd0);
    end
  end

  task automatic do_reset();
    rx_valid = 1'b0;
    start = 1'b0;
    tie0 = 1'b0;
    force1 = 1'b0;
    rst = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("rx_stall", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic wait_end();
    int t;
    rx_valid = 1'b0;
    t = 0;
    while (!(cpu_run || err) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) chk("end_timeout", {31'd0, cpu_run | err}, 32'd1);
  endtask

  task automatic push_pad(input int n);
    for (int i = n; i < DEPTH; i++) q.push_back(NOP);
  endtask

  initial begin
    int n0;
    logic [31:0] w;
    logic [15:0] hdrs [2];
    hdrs[0] = 16'h0000;
    hdrs[1] = 16'h0101;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_en", {31'd0, mem_load_en}, 32'd0);
    chk("rst_inst", mem_load_inst, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_run", {31'd0, cpu_run}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ww", {23'd0, words_written}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // N=2 program plus padding
    n0 = n_en;
    q.push_back(32'h0010_0093);
    q.push_back(32'h0020_0113);
    push_pad(2);
    pulse_start();
    chk("busy_hdr", {31'd0, busy}, 32'd1);
    send_hdr(16'd2, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0020_0113, 0);
    wait_end();
    chk("t1_ww", {23'd0, words_written}, 32'd256);
    chk("t1_nen", n_en - n0, 32'd256);
    chk("t1_run", {31'd0, cpu_run}, 32'd1);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_sb", q.size(), 32'd0);
    chk("t1_done", {31'd0, mem_load_done}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // N=DEPTH with gapped stream
    do_reset();
    n0 = n_en;
    pulse_start();
    send_hdr(16'(DEPTH), 3);
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      q.push_back(w);
      send_word(w, 3);
    end
    wait_end();
    chk("t2_nen", n_en - n0, 32'd256);
    chk("t2_run", {31'd0, cpu_run}, 32'd1);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_sb", q.size(), 32'd0);

    // bad headers
    for (int h = 0; h < 2; h++) begin
      do_reset();
      n0 = n_en;
      pulse_start();
      send_hdr(hdrs[h], 0);
      rx_valid = 1'b0;
      chk("hdr_err", {31'd0, err}, 32'd1);
      chk("hdr_rdy", {31'd0, rx_ready}, 32'd0);
      repeat (4) @(negedge clk);
      chk("hdr_nen", n_en - n0, 32'd0);
      chk("hdr_err2", {31'd0, err}, 32'd1);
    end

    // done never arrives
    do_reset();
    tie0 = 1'b1;
    n0 = n_en;
    q.push_back(32'h0030_0193);
    push_pad(1);
    pulse_start();
    send_hdr(16'd1, 0);
    send_word(32'h0030_0193, 0);
    wait_end();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_delay", cyc - last_en, 32'(TO + 1));
    chk("to_run", {31'd0, cpu_run}, 32'd0);
    chk("to_ww", {23'd0, words_written}, 32'd256);
    chk("to_nen", n_en - n0, 32'd256);
    tie0 = 1'b0;

    // reset mid-DATA, then fresh N=1 load
    do_reset();
    n0 = n_en;
    pulse_start();
    send_hdr(16'd20, 0);
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      q.push_back(w);
      send_word(w, 0);
    end
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    chk("mid_nen", n_en - n0, 32'd10);
    chk("mid_ww", {23'd0, words_written}, 32'd10);
    rst = 1'b1;
    rx_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rdy", {31'd0, rx_ready}, 32'd0);
    chk("mid_en", {31'd0, mem_load_en}, 32'd0);
    chk("mid_inst", mem_load_inst, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ww0", {23'd0, words_written}, 32'd0);
    chk("mid_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    n0 = n_en;
    q.push_back(32'h0050_0293);
    push_pad(1);
    pulse_start();
    send_hdr(16'd1, 0);
    send_word(32'h0050_0293, 0);
    wait_end();
    chk("re_run", {31'd0, cpu_run}, 32'd1);
    chk("re_nen", n_en - n0, 32'd256);
    chk("re_sb", q.size(), 32'd0);

    // start while memory already full
    do_reset();
    force1 = 1'b1;
    n0 = n_en;
    @(negedge clk);
    pulse_start();
    chk("full_err", {31'd0, err}, 32'd1);
    chk("full_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("full_nen", n_en - n0, 32'd0);
    force1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
